// File: rtl/slicer_pkg.sv
// rtl/slicer_pkg.sv - shared types and constants for the slicer pulse meter
// Optional feature macro: SLICER_GAP_MEAS_EN (adds the gap field to the result layout).
package slicer_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        HIGH     = 2'd2
    } meter_state_t;

    // Result layout at the default counter width; the top packs the same
    // fields MSB-first into a flat vector so CNT_W can be overridden.
    typedef struct packed {
        logic                 sat;
        logic [DEF_CNT_W-1:0] width;
`ifdef SLICER_GAP_MEAS_EN
        logic [DEF_CNT_W-1:0] gap;
`endif
    } meter_result_t;

    // Bits per FIFO entry for a given counter width.
    function automatic int result_width(input int cnt_w);
`ifdef SLICER_GAP_MEAS_EN
        return 2 * cnt_w + 1;
`else
        return cnt_w + 1;
`endif
    endfunction

endpackage

// File: rtl/slicer_meter_fifo.sv
// rtl/slicer_meter_fifo.sv - synchronous first-word-fall-through result FIFO
// Ports: clk, rst (async, active-high); wr_valid/wr_data write side;
//        rd_ready pops the head; rd_data is the head entry; full/empty status.
// A write while full is accepted only when a pop happens in the same cycle.
module slicer_meter_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              rd_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_en   = rd_ready && !empty;
    assign wr_en   = wr_valid && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/slicer_pulse_meter.sv
// rtl/slicer_pulse_meter.sv - slicer output pulse-width meter with result FIFO
// Ports: clk, rst (async, active-high); din slicer output (async); enable;
//        min_width glitch threshold; m_valid/m_ready/m_width/m_sat result stream;
//        pulse_count, glitch_count, overflow (sticky) status.
// Optional: SLICER_GAP_MEAS_EN adds output m_gap (low time before each pulse).
module slicer_pulse_meter
    import slicer_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             enable,
    input  logic [7:0]       min_width,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_width,
    output logic             m_sat,
`ifdef SLICER_GAP_MEAS_EN
    output logic [CNT_W-1:0] m_gap,
`endif
    output logic [15:0]      pulse_count,
    output logic [7:0]       glitch_count,
    output logic             overflow
);
    localparam int               RES_W   = result_width(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;
    logic                   ds_d;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            ds_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            ds_d   <= ds;
        end
    end

    assign ds   = sync_q[SYNC_STAGES-1];
    assign rise = ds && !ds_d;
    assign fall = !ds && ds_d;

    // FSM
    meter_state_t state;
    meter_state_t state_nxt;
    logic         start;
    logic         finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    // A rising edge seen right now is measurable; a level that
                    // was already high belongs to a pulse we joined mid-way.
                    if (rise) begin
                        state_nxt = HIGH;
                        start     = 1'b1;
                    end else if (ds) begin
                        state_nxt = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                if (!ds || !enable) begin
                    state_nxt = IDLE;
                end
            end
            HIGH: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (fall) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Width measurement
    logic [CNT_W-1:0] width_q;
    logic             sat_q;
    logic             qualified;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q <= '0;
            sat_q   <= 1'b0;
        end else if (start) begin
            width_q <= CNT_W'(1);
            sat_q   <= 1'b0;
        end else if (state == HIGH && ds) begin
            if (width_q == CNT_MAX) begin
                sat_q <= 1'b1;
            end else begin
                width_q <= width_q + CNT_W'(1);
            end
        end
    end

    assign qualified = finish && (32'(width_q) >= 32'(min_width));

`ifdef SLICER_GAP_MEAS_EN
    // Gap runs from an accepted falling edge; glitches do not restart it.
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_q;
    logic             gap_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt  <= '0;
            gap_q    <= '0;
            gap_seen <= 1'b0;
        end else begin
            if (qualified) begin
                gap_cnt  <= CNT_W'(1);
                gap_seen <= 1'b1;
            end else if (!enable) begin
                gap_seen <= 1'b0;
            end else if (gap_cnt != CNT_MAX) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end
            if (start) begin
                gap_q <= gap_seen ? gap_cnt : CNT_MAX;
            end
        end
    end
`endif

    // Result staging: one register stage between qualification and FIFO write
    logic [RES_W-1:0] res_in;
    logic [RES_W-1:0] push_data_q;
    logic             push_q;
    logic [RES_W-1:0] fifo_data;
    logic [RES_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

`ifdef SLICER_GAP_MEAS_EN
    assign res_in = {sat_q, width_q, gap_q};
`else
    assign res_in = {sat_q, width_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q       <= 1'b0;
            push_data_q  <= '0;
            pulse_count  <= '0;
            glitch_count <= '0;
            overflow     <= 1'b0;
        end else begin
            push_q      <= qualified;
            push_data_q <= res_in;
            if (push_q) begin
                pulse_count <= pulse_count + 16'd1;
                if (fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
            end
            if (finish && !qualified && glitch_count != 8'hFF) begin
                glitch_count <= glitch_count + 8'd1;
            end
        end
    end

    slicer_meter_fifo #(
        .DATA_W (RES_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (push_q),
        .wr_data  (push_data_q),
        .rd_ready (m_ready),
        .rd_data  (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    // Stale storage is masked so the result outputs read 0 while empty.
    assign head    = m_valid ? fifo_data : '0;
    assign m_sat   = head[RES_W-1];
    assign m_width = head[RES_W-2 -: CNT_W];
`ifdef SLICER_GAP_MEAS_EN
    assign m_gap   = head[CNT_W-1:0];
`endif

endmodule

// File: tb/tb_slicer_pulse_meter.sv
// tb/tb_slicer_pulse_meter.sv - directed self-checking bench for slicer_pulse_meter
module tb_slicer_pulse_meter;

    logic        clk;
    logic        rst;
    logic        din;
    logic        enable;
    logic [7:0]  min_width;
    logic        m_ready;
    logic        m_ready4;

    logic        m_valid;
    logic [15:0] m_width;
    logic        m_sat;
    logic [15:0] pulse_count;
    logic [7:0]  glitch_count;
    logic        overflow;

    logic        m_valid4;
    logic [3:0]  m_width4;
    logic        m_sat4;
    logic [15:0] pulse_count4;
    logic [7:0]  glitch_count4;
    logic        overflow4;

`ifdef SLICER_GAP_MEAS_EN
    logic [15:0] m_gap;
    logic [3:0]  m_gap4;
`endif

    int checks = 0;
    int errors = 0;

    slicer_pulse_meter #(.CNT_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .enable       (enable),
        .min_width    (min_width),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_width      (m_width),
        .m_sat        (m_sat),
`ifdef SLICER_GAP_MEAS_EN
        .m_gap        (m_gap),
`endif
        .pulse_count  (pulse_count),
        .glitch_count (glitch_count),
        .overflow     (overflow)
    );

    slicer_pulse_meter #(.CNT_W(4), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .enable       (enable),
        .min_width    (min_width),
        .m_valid      (m_valid4),
        .m_ready      (m_ready4),
        .m_width      (m_width4),
        .m_sat        (m_sat4),
`ifdef SLICER_GAP_MEAS_EN
        .m_gap        (m_gap4),
`endif
        .pulse_count  (pulse_count4),
        .glitch_count (glitch_count4),
        .overflow     (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) tick();
        din = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        din       = 1'b0;
        min_width = 8'd3;
        m_ready   = 1'b0;
        m_ready4  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid",  m_valid,      0);
        check("rst_width",  m_width,      0);
        check("rst_sat",    m_sat,        0);
        check("rst_pcount", pulse_count,  0);
        check("rst_gcount", glitch_count, 0);
        check("rst_ovf",    overflow,     0);
        rst = 1'b0;
        repeat (3) tick();

        // 10-cycle pulse and result latency
        din = 1'b1;
        repeat (10) tick();
        din = 1'b0;
        repeat (3) tick();
        check("lat_early", m_valid, 0);
        tick();
        check("lat_valid",  m_valid,     1);
        check("t1_width",   m_width,     10);
        check("t1_sat",     m_sat,       0);
        check("t1_pcount",  pulse_count, 1);
        pop_one();
        check("t1_popped",  m_valid,     0);
        repeat (3) tick();

        // Glitch threshold
        min_width = 8'd5;
        pulse(4, 4);
        pulse(5, 6);
        check("t2_gcount", glitch_count, 1);
        check("t2_pcount", pulse_count,  2);
        check("t2_valid",  m_valid,      1);
        check("t2_width",  m_width,      5);
        pop_one();
        check("t2_single", m_valid,      0);

        // Overflow with 9 pulses into 8 entries, then in-order drain
        min_width = 8'd1;
        for (int i = 0; i < 9; i++) begin
            pulse(2 + i, 3);
        end
        repeat (4) tick();
        check("t3_ovf",    overflow,    1);
        check("t3_pcount", pulse_count, 11);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_valid%0d", i), m_valid, 1);
            check($sformatf("t3_width%0d", i), m_width, 32'(2 + i));
            pop_one();
        end
        check("t3_empty", m_valid, 0);

        // Abort on enable drop, re-enable with din already high
        din = 1'b1;
        repeat (6) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (4) tick();
        din = 1'b0;
        repeat (6) tick();
        check("t5_none",   m_valid,     0);
        check("t5_pcount", pulse_count, 11);
        pulse(7, 5);
        check("t5_valid",  m_valid,     1);
        check("t5_width",  m_width,     7);
        check("t5_pcount2", pulse_count, 12);

        // Reset with 3 entries queued and a pulse in progress
        pulse(3, 3);
        pulse(4, 5);
        check("t6_pre_pcount", pulse_count, 14);
        din = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        din = 1'b0;
        tick();
        check("t6_valid",  m_valid,      0);
        check("t6_width",  m_width,      0);
        check("t6_pcount", pulse_count,  0);
        check("t6_gcount", glitch_count, 0);
        check("t6_ovf",    overflow,     0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t6_after", m_valid, 0);

        // Saturation on the 4-bit instance; 16-bit instance unsaturated
        pulse(20, 6);
        check("t4_valid4", m_valid4, 1);
        check("t4_width4", m_width4, 15);
        check("t4_sat4",   m_sat4,   1);
        check("t4_width",  m_width,  20);
        check("t4_sat",    m_sat,    0);
`ifdef SLICER_GAP_MEAS_EN
        check("gap_first", m_gap, 16'hFFFF);
`endif
        pop_one();

        // Two pulses separated by 7 low cycles
        pulse(5, 7);
        pulse(5, 6);
        check("g_width1", m_width, 5);
        pop_one();
        check("g_valid2", m_valid, 1);
        check("g_width2", m_width, 5);
`ifdef SLICER_GAP_MEAS_EN
        check("gap_7", m_gap, 7);
`endif
        pop_one();
        check("g_empty", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
